// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch unit for the LEGv8 core.
// Holds one fetched instruction until consumed, then computes the next PC internally.
module pc_fetch_unit #(
  parameter int unsigned         ADDR_W   = 64,
  parameter int unsigned         INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int unsigned         CNT_W    = 32
) (
  input  logic               iCLK,
  input  logic               iReset,
  output logic               oMemReq,
  output logic [ADDR_W-1:0]  oMemAddr,
  input  logic               iMemAck,
  input  logic [INSTR_W-1:0] iMemData,
  output logic               oInstrValid,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [ADDR_W-1:0]  oPC,
  output logic [ADDR_W-1:0]  oPCPlus4,
  input  logic               iInstrReady,
  input  logic [1:0]         iPCSrc,
  input  logic               iCondTrue,
  input  logic [ADDR_W-1:0]  iRegTarget,
  output logic               oFault,
  output logic [CNT_W-1:0]   oInstrCount
);

  typedef enum logic [1:0] {StIdle, StFetch, StValid, StFault} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [ADDR_W-1:0]    pc_plus4;
  logic [ADDR_W-1:0]    cond_off;
  logic [ADDR_W-1:0]    unc_off;
  logic [ADDR_W-1:0]    next_pc;

  assign pc_plus4 = pc_q + ADDR_W'(4);

  // Word offsets shifted to byte offsets, then sign-extended to the full PC width.
  always_comb begin
    cond_off        = {ADDR_W{instr_q[23]}};
    cond_off[20:0]  = {instr_q[23:5], 2'b00};
    unc_off         = {ADDR_W{instr_q[25]}};
    unc_off[27:0]   = {instr_q[25:0], 2'b00};
    case (iPCSrc)
      2'b00:   next_pc = pc_plus4;
      2'b01:   next_pc = iCondTrue ? (pc_q + cond_off) : pc_plus4;
      2'b10:   next_pc = pc_q + unc_off;
      default: next_pc = iRegTarget;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (iMemAck) begin
          instr_d = iMemData;
          state_d = StValid;
        end
      end
      StValid: begin
        if (iInstrReady) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (next_pc[1:0] != 2'b00) begin
            state_d = StFault;
          end else begin
            pc_d    = next_pc;
            state_d = StFetch;
          end
        end
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK or negedge iReset) begin
    if (!iReset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oMemReq      = (state_q == StFetch);
  assign oMemAddr     = pc_q;
  assign oInstrValid  = (state_q == StValid);
  assign oInstruction = instr_q;
  assign oPC          = pc_q;
  assign oPCPlus4     = pc_plus4;
  assign oFault       = (state_q == StFault);
  assign oInstrCount  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a cycle-by-cycle vector table plus hand-written
// reset and counter-wrap sequences. A second instance with a 4-bit counter shares stimulus.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        rdy;
  logic [1:0]  src;
  logic        cond;
  logic [63:0] tgt;

  logic        req, valid, fault;
  logic [63:0] addr, pc, pc4;
  logic [31:0] ins, cnt;

  logic        s_req, s_valid, s_fault;
  logic [63:0] s_addr, s_pc, s_pc4;
  logic [31:0] s_ins;
  logic [3:0]  s_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_fetch_unit u_dut (
    .iCLK(clk), .iReset(rst_n), .oMemReq(req), .oMemAddr(addr), .iMemAck(mem_ack),
    .iMemData(mem_data), .oInstrValid(valid), .oInstruction(ins), .oPC(pc), .oPCPlus4(pc4),
    .iInstrReady(rdy), .iPCSrc(src), .iCondTrue(cond), .iRegTarget(tgt), .oFault(fault),
    .oInstrCount(cnt)
  );

  pc_fetch_unit #(.CNT_W(4)) u_small (
    .iCLK(clk), .iReset(rst_n), .oMemReq(s_req), .oMemAddr(s_addr), .iMemAck(mem_ack),
    .iMemData(mem_data), .oInstrValid(s_valid), .oInstruction(s_ins), .oPC(s_pc),
    .oPCPlus4(s_pc4), .iInstrReady(rdy), .iPCSrc(src), .iCondTrue(cond), .iRegTarget(tgt),
    .oFault(s_fault), .oInstrCount(s_cnt)
  );

  typedef struct {
    logic        ack;
    logic [31:0] data;
    logic        rdy;
    logic [1:0]  src;
    logic        cond;
    logic [63:0] tgt;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_val;
    logic [31:0] e_ins;
    logic [63:0] e_pc;
    logic        e_flt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [34];

  // Fetch cycle: ready is driven high to show it is ignored outside VALID.
  function automatic vec_t fv(input logic [63:0] a, input logic ack, input logic [31:0] d,
                              input logic [31:0] c);
    vec_t v;
    v = '{ack: ack, data: d, rdy: 1'b1, src: 2'b00, cond: 1'b0, tgt: 64'h0, e_req: 1'b1,
          e_addr: a, e_val: 1'b0, e_ins: 32'h0, e_pc: a, e_flt: 1'b0, e_cnt: c};
    return v;
  endfunction

  // Valid cycle: ack with garbage data is driven to show it is ignored outside FETCH.
  function automatic vec_t vv(input logic [63:0] p, input logic [31:0] i, input logic r,
                              input logic [1:0] s, input logic cd, input logic [63:0] t,
                              input logic [31:0] c);
    vec_t v;
    v = '{ack: 1'b1, data: 32'hFFFF_FFFF, rdy: r, src: s, cond: cd, tgt: t, e_req: 1'b0,
          e_addr: p, e_val: 1'b1, e_ins: i, e_pc: p, e_flt: 1'b0, e_cnt: c};
    return v;
  endfunction

  function automatic vec_t tv(input logic [63:0] p, input logic [31:0] c);
    vec_t v;
    v = '{ack: 1'b1, data: 32'h1234_5678, rdy: 1'b1, src: 2'b00, cond: 1'b0, tgt: 64'h0,
          e_req: 1'b0, e_addr: p, e_val: 1'b0, e_ins: 32'h0, e_pc: p, e_flt: 1'b1, e_cnt: c};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    mem_ack  = 1'b0;
    mem_data = 32'h0;
    rdy      = 1'b0;
    src      = 2'b00;
    cond     = 1'b0;
    tgt      = 64'h0;

    vecs[0]  = '{ack: 1'b1, data: 32'hDEAD_BEEF, rdy: 1'b1, src: 2'b00, cond: 1'b0, tgt: 64'h0,
                 e_req: 1'b0, e_addr: 64'h0, e_val: 1'b0, e_ins: 32'h0, e_pc: 64'h0,
                 e_flt: 1'b0, e_cnt: 32'd0};
    vecs[1]  = fv(64'h0,   1'b1, 32'h1111_1111, 0);
    vecs[2]  = vv(64'h0,   32'h1111_1111, 1'b1, 2'b00, 1'b0, 64'h0, 0);
    vecs[3]  = fv(64'h4,   1'b1, 32'h2222_2222, 1);
    vecs[4]  = vv(64'h4,   32'h2222_2222, 1'b1, 2'b00, 1'b0, 64'h0, 1);
    vecs[5]  = fv(64'h8,   1'b1, 32'h3333_3333, 2);
    vecs[6]  = vv(64'h8,   32'h3333_3333, 1'b1, 2'b00, 1'b0, 64'h0, 2);
    vecs[7]  = fv(64'hC,   1'b1, 32'h4444_4444, 3);
    vecs[8]  = vv(64'hC,   32'h4444_4444, 1'b1, 2'b00, 1'b0, 64'h0, 3);
    vecs[9]  = fv(64'h10,  1'b0, 32'h0, 4);
    vecs[10] = fv(64'h10,  1'b0, 32'h0, 4);
    vecs[11] = fv(64'h10,  1'b0, 32'h0, 4);
    vecs[12] = fv(64'h10,  1'b1, 32'h5555_5555, 4);
    vecs[13] = vv(64'h10,  32'h5555_5555, 1'b0, 2'b00, 1'b0, 64'h0, 4);
    vecs[14] = vv(64'h10,  32'h5555_5555, 1'b0, 2'b00, 1'b0, 64'h0, 4);
    vecs[15] = vv(64'h10,  32'h5555_5555, 1'b1, 2'b11, 1'b0, 64'h40, 4);
    vecs[16] = fv(64'h40,  1'b1, 32'hB4FF_FFC0, 5);
    vecs[17] = vv(64'h40,  32'hB4FF_FFC0, 1'b1, 2'b01, 1'b1, 64'h0, 5);
    vecs[18] = fv(64'h38,  1'b1, 32'h1234_5678, 6);
    vecs[19] = vv(64'h38,  32'h1234_5678, 1'b1, 2'b11, 1'b0, 64'h40, 6);
    vecs[20] = fv(64'h40,  1'b1, 32'hB4FF_FFC0, 7);
    vecs[21] = vv(64'h40,  32'hB4FF_FFC0, 1'b1, 2'b01, 1'b0, 64'h0, 7);
    vecs[22] = fv(64'h44,  1'b1, 32'h0000_0000, 8);
    vecs[23] = vv(64'h44,  32'h0000_0000, 1'b1, 2'b11, 1'b0, 64'h100, 8);
    vecs[24] = fv(64'h100, 1'b1, 32'h1400_0010, 9);
    vecs[25] = vv(64'h100, 32'h1400_0010, 1'b1, 2'b10, 1'b0, 64'h0, 9);
    vecs[26] = fv(64'h140, 1'b1, 32'h17FF_FFFF, 10);
    vecs[27] = vv(64'h140, 32'h17FF_FFFF, 1'b1, 2'b10, 1'b0, 64'h0, 10);
    vecs[28] = fv(64'h13C, 1'b1, 32'h17FF_FFF1, 11);
    vecs[29] = vv(64'h13C, 32'h17FF_FFF1, 1'b1, 2'b10, 1'b0, 64'h0, 11);
    vecs[30] = fv(64'h100, 1'b1, 32'hD61F_0000, 12);
    vecs[31] = vv(64'h100, 32'hD61F_0000, 1'b1, 2'b11, 1'b0, 64'h1002, 12);
    vecs[32] = tv(64'h100, 13);
    vecs[33] = tv(64'h100, 13);

    repeat (2) tick();
    chk("rst_req",   {63'h0, req},   64'h0);
    chk("rst_addr",  addr,           64'h0);
    chk("rst_valid", {63'h0, valid}, 64'h0);
    chk("rst_instr", {32'h0, ins},   64'h0);
    chk("rst_pc",    pc,             64'h0);
    chk("rst_pc4",   pc4,            64'h4);
    chk("rst_fault", {63'h0, fault}, 64'h0);
    chk("rst_cnt",   {32'h0, cnt},   64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 34; i++) begin
      mem_ack  = vecs[i].ack;
      mem_data = vecs[i].data;
      rdy      = vecs[i].rdy;
      src      = vecs[i].src;
      cond     = vecs[i].cond;
      tgt      = vecs[i].tgt;
      chk($sformatf("v%0d_req", i),   {63'h0, req},   {63'h0, vecs[i].e_req});
      chk($sformatf("v%0d_valid", i), {63'h0, valid}, {63'h0, vecs[i].e_val});
      chk($sformatf("v%0d_fault", i), {63'h0, fault}, {63'h0, vecs[i].e_flt});
      chk($sformatf("v%0d_cnt", i),   {32'h0, cnt},   {32'h0, vecs[i].e_cnt});
      if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), addr, vecs[i].e_addr);
      if (vecs[i].e_val) chk($sformatf("v%0d_instr", i), {32'h0, ins}, {32'h0, vecs[i].e_ins});
      if (vecs[i].e_val || vecs[i].e_flt) begin
        chk($sformatf("v%0d_pc", i),  pc,  vecs[i].e_pc);
        chk($sformatf("v%0d_pc4", i), pc4, vecs[i].e_pc + 64'h4);
      end
      tick();
    end

    // Clear the fault, then assert reset in the middle of an acked FETCH cycle.
    mem_ack = 1'b0;
    rdy     = 1'b0;
    src     = 2'b00;
    rst_n   = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("clr_fault", {63'h0, fault}, 64'h0);
    tick();
    chk("mid_req", {63'h0, req}, 64'h1);
    mem_ack  = 1'b1;
    mem_data = 32'hAAAA_AAAA;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req",   {63'h0, req},   64'h0);
    chk("async_valid", {63'h0, valid}, 64'h0);
    chk("async_cnt",   {32'h0, cnt},   64'h0);
    tick();
    mem_ack = 1'b0;
    rst_n   = 1'b1;
    chk("mid_instr", {32'h0, ins},   64'h0);
    chk("mid_valid", {63'h0, valid}, 64'h0);
    chk("mid_idle",  {63'h0, req},   64'h0);
    tick();

    // 17 zero-wait sequential consumes; the 4-bit counter wraps to 1.
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("seq%0d_req", k),  {63'h0, req}, 64'h1);
      chk($sformatf("seq%0d_addr", k), addr, 64'(4 * k));
      mem_ack  = 1'b1;
      mem_data = 32'h100 + 32'(k);
      tick();
      mem_ack = 1'b0;
      chk($sformatf("seq%0d_valid", k), {63'h0, valid}, 64'h1);
      chk($sformatf("seq%0d_instr", k), {32'h0, ins}, 64'h100 + 64'(k));
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
    end
    chk("wrap_addr",      addr,              64'd68);
    chk("wrap_cnt32",     {32'h0, cnt},      64'd17);
    chk("wrap_cnt4",      {60'h0, s_cnt},    64'd1);
    chk("wrap_small_req", {63'h0, s_req},    64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
